// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the multiplexed seven-segment scanner.
// Holds the scan FSM state enum, the active-low segment table and blank patterns.
// No ports; imported by seven_seg_scan and hex_to_seg.
package seven_seg_pkg;

    typedef enum logic {
        ST_DEAD = 1'b0,
        ST_SHOW = 1'b1
    } scan_state_t;

    // Active-low cathode patterns {g,f,e,d,c,b,a}; element [h] is the glyph for hex h.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;

endpackage

// File: rtl/hex_to_seg.sv
// Hex nibble to active-low seven-segment pattern, purely combinational.
// Ports: hex_i [3:0] nibble in; seg_o [6:0] cathodes {g,f,e,d,c,b,a}, active-low.
// Zero latency, no flow control.
module hex_to_seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_TABLE[hex_i];

endmodule

// File: rtl/seven_seg_scan.sv
// Four-digit multiplexed seven-segment driver with blanking dead time, double-buffered
// value/decimal-point registers swapped at frame boundaries, and leading-zero suppression.
// Ports: clk_i/rst_i (async active-high); value_i, dp_in_i, load_i, lz_sup_i in;
// seg_o, dp_o, an_o (all active-low) and frame_done_o out, all registered.
module seven_seg_scan #(
    parameter int REFRESH_DIV = 100000,
    parameter int DEAD_CYCLES = 1000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] value_i,
    input  logic [3:0]  dp_in_i,
    input  logic        load_i,
    input  logic        lz_sup_i,
    output logic [6:0]  seg_o,
    output logic        dp_o,
    output logic [3:0]  an_o,
    output logic        frame_done_o
);
    import seven_seg_pkg::*;

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    scan_state_t      state_q, state_d;
    logic [15:0]      shadow_val_q, shadow_val_d;
    logic [3:0]       shadow_dp_q, shadow_dp_d;
    logic [15:0]      active_val_q, active_val_d;
    logic [3:0]       active_dp_q, active_dp_d;
    logic             pending_q, pending_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic [3:0]       an_q, an_d;
    logic             frame_done_q, frame_done_d;

    logic             slot_end;
    logic             boundary;
    logic [15:0]      upper;
    logic             lz_blank;
    logic [6:0]       seg_dec;

    // upper[3:0] is the current digit; the whole word is zero only when this digit
    // and every more-significant digit are zero, which is the suppression test.
    assign upper = active_val_q >> {idx_q, 2'b00};

    hex_to_seg u_hex_to_seg (
        .hex_i (upper[3:0]),
        .seg_o (seg_dec)
    );

    always_comb begin
        slot_end = (cnt_q == CNT_LAST);
        boundary = slot_end && (idx_q == 2'd3);

        cnt_d   = slot_end ? '0 : cnt_q + 1'b1;
        idx_d   = slot_end ? idx_q + 2'd1 : idx_q;
        // State tracks the counter value it will sit next to, so DEAD spans counts 0..DEAD_CYCLES-1.
        state_d = (int'(cnt_d) < DEAD_CYCLES) ? ST_DEAD : ST_SHOW;

        shadow_val_d = load_i ? value_i : shadow_val_q;
        shadow_dp_d  = load_i ? dp_in_i : shadow_dp_q;
        active_val_d = active_val_q;
        active_dp_d  = active_dp_q;
        pending_d    = pending_q;
        if (boundary) begin
            // A load landing exactly on the boundary goes straight to the active copy.
            pending_d = 1'b0;
            if (load_i) begin
                active_val_d = value_i;
                active_dp_d  = dp_in_i;
            end else if (pending_q) begin
                active_val_d = shadow_val_q;
                active_dp_d  = shadow_dp_q;
            end
        end else if (load_i) begin
            pending_d = 1'b1;
        end

        lz_blank = lz_sup_i && (idx_q != 2'd0) && (upper == 16'h0000) && !active_dp_q[idx_q];

        if ((state_q == ST_DEAD) || lz_blank) begin
            an_d  = AN_OFF;
            seg_d = SEG_BLANK;
            dp_d  = 1'b1;
        end else begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = seg_dec;
            dp_d  = ~active_dp_q[idx_q];
        end

        frame_done_d = boundary;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            state_q      <= ST_DEAD;
            shadow_val_q <= 16'h0000;
            shadow_dp_q  <= 4'h0;
            active_val_q <= 16'h0000;
            active_dp_q  <= 4'h0;
            pending_q    <= 1'b0;
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b1;
            an_q         <= AN_OFF;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            state_q      <= state_d;
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            active_val_q <= active_val_d;
            active_dp_q  <= active_dp_d;
            pending_q    <= pending_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg_o        = seg_q;
    assign dp_o         = dp_q;
    assign an_o         = an_q;
    assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
module tb_seven_seg_scan;

    localparam int DIV   = 4;
    localparam int DEAD  = 1;
    localparam int FRAME = 4 * DIV;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [15:0] value_i = 16'h0000;
    logic [3:0]  dp_in_i = 4'h0;
    logic        load_i = 1'b0;
    logic        lz_sup_i = 1'b0;
    logic [6:0]  seg_o;
    logic        dp_o;
    logic [3:0]  an_o;
    logic        frame_done_o;

    seven_seg_scan #(.REFRESH_DIV(DIV), .DEAD_CYCLES(DEAD)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .value_i      (value_i),
        .dp_in_i      (dp_in_i),
        .load_i       (load_i),
        .lz_sup_i     (lz_sup_i),
        .seg_o        (seg_o),
        .dp_o         (dp_o),
        .an_o         (an_o),
        .frame_done_o (frame_done_o)
    );

    always #5 clk_i = ~clk_i;

    int n_pass = 0;
    int n_chk  = 0;

    // Reference model: elapsed cycles since reset plus the displayed and buffered words.
    int          t;
    logic [15:0] m_act, m_sh;
    logic [3:0]  m_adp, m_sdp;
    bit          m_pend;
    bit          lz_cur;

    function automatic logic [6:0] seg_ref(input logic [3:0] h);
        case (h)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
    endtask

    task automatic model_reset();
        t = 0; m_act = 0; m_sh = 0; m_adp = 0; m_sdp = 0; m_pend = 0;
    endtask

    task automatic check_blank(input string tag);
        check({tag, "_an"},  {28'd0, an_o},  32'hF);
        check({tag, "_seg"}, {25'd0, seg_o}, 32'h7F);
        check({tag, "_dp"},  {31'd0, dp_o},  32'h1);
        check({tag, "_fd"},  {31'd0, frame_done_o}, 32'h0);
    endtask

    // One clock: drive inputs at negedge, predict outputs from the pre-edge model, check after the edge.
    task automatic tick(input bit ld, input logic [15:0] v, input logic [3:0] d);
        int          slot, pos;
        logic [15:0] hi;
        logic [3:0]  e_an;
        logic [6:0]  e_seg;
        logic        e_dp, e_fd;
        bit          sup;
        @(negedge clk_i);
        rst_i = 1'b0; load_i = ld; value_i = v; dp_in_i = d; lz_sup_i = lz_cur;
        slot = (t / DIV) % 4;
        pos  = t % DIV;
        hi   = m_act / (16'd1 << (4 * slot));
        sup  = lz_cur && (slot != 0) && (hi == 0) && !m_adp[slot];
        if (pos < DEAD || sup) begin
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
        end else begin
            e_an  = 4'hF & ~(4'(1) << slot);
            e_seg = seg_ref(hi[3:0]);
            e_dp  = !m_adp[slot];
        end
        e_fd = ((t % FRAME) == FRAME - 1);
        if (e_fd) begin
            if (ld) begin m_act = v; m_adp = d; end
            else if (m_pend) begin m_act = m_sh; m_adp = m_sdp; end
            m_pend = 0;
            if (ld) begin m_sh = v; m_sdp = d; end
        end else if (ld) begin
            m_sh = v; m_sdp = d; m_pend = 1;
        end
        t++;
        @(posedge clk_i);
        #1;
        check("an",  {28'd0, an_o},  {28'd0, e_an});
        check("seg", {25'd0, seg_o}, {25'd0, e_seg});
        check("dp",  {31'd0, dp_o},  {31'd0, e_dp});
        check("fd",  {31'd0, frame_done_o}, {31'd0, e_fd});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 16'h0000, 4'h0);
    endtask

    task automatic run_to(input int phase);
        while ((t % FRAME) != phase) tick(0, 16'h0000, 4'h0);
    endtask

    initial begin
        logic [15:0] rv, mask;
        bit          rl;
        lz_cur = 0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk_i);
        #1;
        check_blank("reset");

        // 0x1234 loaded, visible one frame later
        tick(1, 16'h1234, 4'h0);
        idle(2 * FRAME);

        // 0x5555 shown; 0xAAAA loaded during digit 1 must not tear the frame
        run_to(FRAME - 2);
        tick(1, 16'h5555, 4'h0);
        idle(FRAME);
        run_to(5);
        tick(1, 16'hAAAA, 4'h0);
        idle(2 * FRAME);

        // Two loads in one frame: last wins
        run_to(2);
        tick(1, 16'h1111, 4'h0);
        tick(1, 16'h9C7E, 4'h0);
        idle(2 * FRAME);

        // Load in the exact boundary cycle bypasses the shadow
        run_to(FRAME - 1);
        tick(1, 16'h0F08, 4'h0);
        idle(FRAME);

        // Leading-zero suppression
        lz_cur = 1;
        tick(1, 16'h0050, 4'h0);
        idle(2 * FRAME);
        tick(1, 16'h0000, 4'h0);
        idle(2 * FRAME);
        // Decimal point on a zero digit keeps it lit
        tick(1, 16'h0000, 4'b0100);
        idle(2 * FRAME);
        lz_cur = 0;

        // Decimal point on digit 2 only
        tick(1, 16'h8888, 4'b0100);
        idle(2 * FRAME);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ((i % 48) == 0) lz_cur = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 4))
                0: mask = 16'hFFFF;
                1: mask = 16'h0FFF;
                2: mask = 16'h00FF;
                3: mask = 16'h000F;
                default: mask = 16'h0000;
            endcase
            rv = 16'($urandom) & mask;
            rl = ($urandom_range(0, 7) == 0);
            tick(rl, rv, 4'($urandom));
        end

        // Reset in the middle of digit 2 SHOW, with a load pending under reset
        lz_cur = 0;
        tick(1, 16'h4321, 4'hF);
        idle(FRAME);
        run_to(2 * DIV + DEAD + 1);
        @(negedge clk_i);
        rst_i = 1'b1; load_i = 1'b1; value_i = 16'hFFFF; dp_in_i = 4'hF;
        #1;
        check_blank("rst_mid");
        repeat (2) @(posedge clk_i);
        #1;
        check_blank("rst_hold");
        model_reset();
        idle(2 * FRAME);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
